// File: rtl/ap_ctrl_launcher.sv
// ap_ctrl_launcher: control-bus front end for an ap_ctrl style downstream stage.
// Converts the level start bit of the control register into a single start pulse,
// freezes the two argument registers for the duration of a run, reports idle/busy,
// and keeps sticky done/timeout status plus the BUSY-cycle count of the last run.
//
// Ports:
//   ap_clk, ap_rst     clock (rising edge), asynchronous active-high reset
//   ap_start_i         start level from control register
//   status_clr_i       1-cycle pulse on status read, clears sticky bits
//   arg0_i, arg1_i     argument values from control register
//   ap_done_i          1-cycle done pulse from downstream stage
//   ap_start_pedge_o   1-cycle start pulse to downstream stage
//   reg0_o, reg1_o     arguments latched at launch, stable for the whole run
//   ap_idle_o          high while idle
//   ap_busy_o          high while launching or running
//   ap_done_sticky_o   last run finished via ap_done_i (held until cleared)
//   ap_timeout_o       last run aborted by the watchdog (held until cleared)
//   run_cycles_o       BUSY-cycle count of the last finished run
module ap_ctrl_launcher #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start_i,
  input  logic              status_clr_i,
  input  logic [DATA_W-1:0] arg0_i,
  input  logic [DATA_W-1:0] arg1_i,
  input  logic              ap_done_i,
  output logic              ap_start_pedge_o,
  output logic [DATA_W-1:0] reg0_o,
  output logic [DATA_W-1:0] reg1_o,
  output logic              ap_idle_o,
  output logic              ap_busy_o,
  output logic              ap_done_sticky_o,
  output logic              ap_timeout_o,
  output logic [CNT_W-1:0]  run_cycles_o
);

  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutVal  = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StBusy
  } state_e;

  state_e state_q, state_d;

  logic              start_prev_q;
  logic              rise;
  logic [CNT_W-1:0]  wdog_q, wdog_d;
  logic [CNT_W-1:0]  run_cycles_q, run_cycles_d;
  logic [DATA_W-1:0] reg0_q, reg0_d;
  logic [DATA_W-1:0] reg1_q, reg1_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              set_done, set_timeout;

  // start_prev resets high so a start level held through reset cannot launch.
  assign rise = ap_start_i & ~start_prev_q;

  always_comb begin
    state_d      = state_q;
    wdog_d       = wdog_q;
    run_cycles_d = run_cycles_q;
    reg0_d       = reg0_q;
    reg1_d       = reg1_q;
    set_done     = 1'b0;
    set_timeout  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StLaunch;
          reg0_d  = arg0_i;
          reg1_d  = arg1_i;
          wdog_d  = '0;
        end
      end
      StLaunch: begin
        state_d = StBusy;
      end
      StBusy: begin
        wdog_d = wdog_q + 1'b1;
        // Done on the final watchdog cycle still counts as a normal completion.
        if (ap_done_i) begin
          state_d      = StIdle;
          set_done     = 1'b1;
          run_cycles_d = wdog_q + 1'b1;
        end else if (wdog_q == TimeoutLast) begin
          state_d      = StIdle;
          set_timeout  = 1'b1;
          run_cycles_d = TimeoutVal;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Setting a sticky bit wins over a coincident clear.
    done_d    = set_done    | (done_q    & ~status_clr_i);
    timeout_d = set_timeout | (timeout_q & ~status_clr_i);
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q      <= StIdle;
      start_prev_q <= 1'b1;
      wdog_q       <= '0;
      run_cycles_q <= '0;
      reg0_q       <= '0;
      reg1_q       <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= ap_start_i;
      wdog_q       <= wdog_d;
      run_cycles_q <= run_cycles_d;
      reg0_q       <= reg0_d;
      reg1_q       <= reg1_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign ap_start_pedge_o = (state_q == StLaunch);
  assign ap_idle_o        = (state_q == StIdle);
  assign ap_busy_o        = (state_q == StLaunch) || (state_q == StBusy);
  assign reg0_o           = reg0_q;
  assign reg1_o           = reg1_q;
  assign ap_done_sticky_o = done_q;
  assign ap_timeout_o     = timeout_q;
  assign run_cycles_o     = run_cycles_q;

endmodule

// File: tb/tb_ap_ctrl_launcher.sv
module tb_ap_ctrl_launcher;

  localparam int unsigned TO = 16;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start_i;
  logic        status_clr_i;
  logic [31:0] arg0_i;
  logic [31:0] arg1_i;
  logic        ap_done_i;
  logic        ap_start_pedge_o;
  logic [31:0] reg0_o;
  logic [31:0] reg1_o;
  logic        ap_idle_o;
  logic        ap_busy_o;
  logic        ap_done_sticky_o;
  logic        ap_timeout_o;
  logic [31:0] run_cycles_o;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: what register readback should show.
  bit          exp_done;
  bit          exp_to;
  logic [31:0] exp_reg0;
  logic [31:0] exp_reg1;
  logic [31:0] exp_cycles;

  ap_ctrl_launcher #(
    .DATA_W        (32),
    .CNT_W         (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .ap_clk          (ap_clk),
    .ap_rst          (ap_rst),
    .ap_start_i      (ap_start_i),
    .status_clr_i    (status_clr_i),
    .arg0_i          (arg0_i),
    .arg1_i          (arg1_i),
    .ap_done_i       (ap_done_i),
    .ap_start_pedge_o(ap_start_pedge_o),
    .reg0_o          (reg0_o),
    .reg1_o          (reg1_o),
    .ap_idle_o       (ap_idle_o),
    .ap_busy_o       (ap_busy_o),
    .ap_done_sticky_o(ap_done_sticky_o),
    .ap_timeout_o    (ap_timeout_o),
    .run_cycles_o    (run_cycles_o)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Sticky-bit rule: a set in a cycle beats a clear in the same cycle.
  task automatic model_status(input bit set_d, input bit set_t, input bit clr);
    exp_done = set_d ? 1'b1 : (clr ? 1'b0 : exp_done);
    exp_to   = set_t ? 1'b1 : (clr ? 1'b0 : exp_to);
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_done"},   64'(ap_done_sticky_o), 64'(exp_done));
    chk({tag, "_to"},     64'(ap_timeout_o),     64'(exp_to));
    chk({tag, "_cycles"}, 64'(run_cycles_o),     64'(exp_cycles));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_idle"},  64'(ap_idle_o),        64'd1);
    chk({tag, "_busy"},  64'(ap_busy_o),        64'd0);
    chk({tag, "_pedge"}, 64'(ap_start_pedge_o), 64'd0);
    chk({tag, "_reg0"},  64'(reg0_o),           64'd0);
    chk({tag, "_reg1"},  64'(reg1_o),           64'd0);
    chk_status(tag);
  endtask

  // One complete run. d = BUSY cycle on which ap_done_i pulses (0 or >TO: never).
  // quiet = force a status clear on the ending cycle and keep the idle tail clear-free.
  task automatic run_one(input logic [31:0] a0, input logic [31:0] a1, input int d,
                         input bit quiet);
    bit by_done;
    int end_n;
    bit clr;
    int idle_n;
    by_done = (d >= 1) && (d <= int'(TO));
    end_n   = by_done ? d : int'(TO);

    arg0_i = a0; arg1_i = a1; ap_start_i = 1'b1; ap_done_i = 1'b0; status_clr_i = 1'b0;
    tick();
    exp_reg0 = a0;
    exp_reg1 = a1;
    chk("launch_pedge", 64'(ap_start_pedge_o), 64'd1);
    chk("launch_busy",  64'(ap_busy_o),        64'd1);
    chk("launch_reg0",  64'(reg0_o),           64'(exp_reg0));
    chk("launch_reg1",  64'(reg1_o),           64'(exp_reg1));

    // Done pulses and arg changes during the launch cycle must be ignored.
    arg0_i = $urandom; arg1_i = $urandom; ap_start_i = 1'($urandom_range(0, 1));
    ap_done_i = 1'($urandom_range(0, 1));
    clr = 1'($urandom_range(0, 1));
    status_clr_i = clr;
    tick();
    model_status(1'b0, 1'b0, clr);

    for (int n = 1; n <= end_n; n++) begin
      chk("busy_pedge", 64'(ap_start_pedge_o), 64'd0);
      chk("busy_busy",  64'(ap_busy_o),        64'd1);
      chk("busy_reg0",  64'(reg0_o),           64'(exp_reg0));
      chk("busy_reg1",  64'(reg1_o),           64'(exp_reg1));
      chk_status("busy");
      // Start edges and argument changes mid-run are dropped.
      arg0_i = $urandom; arg1_i = $urandom; ap_start_i = 1'($urandom_range(0, 1));
      ap_done_i = (n == d);
      clr = (n == end_n && quiet) ? 1'b1 : ($urandom_range(0, 3) == 0);
      status_clr_i = clr;
      tick();
      if (n == end_n) begin
        exp_cycles = 32'(end_n);
        model_status(by_done, !by_done, clr);
      end else begin
        model_status(1'b0, 1'b0, clr);
      end
    end

    chk("end_idle",  64'(ap_idle_o), 64'd1);
    chk("end_busy",  64'(ap_busy_o), 64'd0);
    chk("end_reg0",  64'(reg0_o),    64'(exp_reg0));
    chk_status("end");

    idle_n = quiet ? 1 : int'($urandom_range(1, 3));
    for (int k = 0; k < idle_n; k++) begin
      ap_start_i = 1'b0;
      ap_done_i = quiet ? 1'b0 : 1'($urandom_range(0, 1));
      clr = quiet ? 1'b0 : 1'($urandom_range(0, 1));
      status_clr_i = clr;
      tick();
      model_status(1'b0, 1'b0, clr);
      chk("idle_idle",  64'(ap_idle_o),        64'd1);
      chk("idle_pedge", 64'(ap_start_pedge_o), 64'd0);
      chk_status("idle");
    end
    ap_done_i = 1'b0;
    status_clr_i = 1'b0;
  endtask

  initial begin
    exp_done = 1'b0; exp_to = 1'b0; exp_reg0 = '0; exp_reg1 = '0; exp_cycles = '0;
    ap_rst = 1'b1; ap_start_i = 1'b1; status_clr_i = 1'b0;
    arg0_i = 32'h1234; arg1_i = 32'h5678; ap_done_i = 1'b0;
    #3;
    chk_reset_vals("rst");
    tick();
    tick();
    ap_rst = 1'b0;

    // Start level held high through reset must not launch.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("held_pedge", 64'(ap_start_pedge_o), 64'd0);
      chk("held_idle",  64'(ap_idle_o),        64'd1);
    end
    ap_start_i = 1'b0;
    tick();

    // Basic run: done 10 cycles after the pulse.
    run_one(32'h1, 32'h0, 10, 1'b0);
    // Timeout boundary: no done, done on the last cycle, done just too late.
    run_one(32'hA5A5_0001, 32'h0F0F_F0F0, 0, 1'b0);
    run_one(32'hA5A5_0002, 32'h1, int'(TO), 1'b0);
    run_one(32'hA5A5_0003, 32'h2, int'(TO) + 1, 1'b0);
    run_one(32'hA5A5_0004, 32'h3, 1, 1'b0);

    // Clear coincident with done set keeps the bit; a later clear drops it.
    run_one(32'h55, 32'h66, 5, 1'b1);
    chk("clr_coinc_done", 64'(ap_done_sticky_o), 64'd1);
    status_clr_i = 1'b1;
    tick();
    model_status(1'b0, 1'b0, 1'b1);
    status_clr_i = 1'b0;
    chk("clr_next_done", 64'(ap_done_sticky_o), 64'd0);
    chk_status("clr_next");

    // Same for timeout.
    run_one(32'h77, 32'h88, 0, 1'b1);
    chk("clr_coinc_to", 64'(ap_timeout_o), 64'd1);
    status_clr_i = 1'b1;
    tick();
    model_status(1'b0, 1'b0, 1'b1);
    status_clr_i = 1'b0;
    chk_status("clr_next_to");

    for (int r = 0; r < 40; r++) begin
      run_one($urandom, $urandom, int'($urandom_range(0, TO + 4)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a run.
    arg0_i = 32'hDEAD; arg1_i = 32'hBEEF; ap_start_i = 1'b1;
    tick();
    ap_start_i = 1'b0;
    tick();
    tick();
    ap_rst = 1'b1;
    #2;
    exp_done = 1'b0; exp_to = 1'b0; exp_reg0 = '0; exp_reg1 = '0; exp_cycles = '0;
    chk_reset_vals("midrst");
    tick();
    ap_rst = 1'b0;
    tick();
    chk("post_rst_pedge", 64'(ap_start_pedge_o), 64'd0);
    chk("post_rst_idle",  64'(ap_idle_o),        64'd1);
    run_one(32'hCAFE, 32'hF00D, 3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
